// File: rtl/el2_pkg.sv
// Shared types and constants for the decode-stage trigger unit.
package el2_pkg;

    localparam int unsigned EL2_TRIG_MAX = 8;

    typedef enum logic [1:0] {
        TRIG_EQ   = 2'd0,
        TRIG_MASK = 2'd1,
        TRIG_GE   = 2'd2,
        TRIG_LT   = 2'd3
    } el2_trig_mode_e;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } el2_trigger_pkt_t;

endpackage

// File: rtl/el2_dec_trig_cmp.sv
// One trigger channel's combinational comparator: EQ, NAPOT MASK, GE and LT, all unsigned.
module el2_dec_trig_cmp
    import el2_pkg::*;
(
    input  logic [31:0]    i_data,
    input  logic [31:0]    i_tdata2,
    input  el2_trig_mode_e i_mode,
    output logic           o_cmp
);

    // Trailing ones of tdata2 plus the first zero above them are don't-care.
    logic [31:0] w_dont_care;
    assign w_dont_care = i_tdata2 ^ (i_tdata2 + 32'd1);

    always_comb begin
        o_cmp = 1'b0;
        case (i_mode)
            TRIG_EQ:   o_cmp = (i_data == i_tdata2);
            TRIG_MASK: o_cmp = (((i_data ^ i_tdata2) & ~w_dont_care) == 32'd0);
            TRIG_GE:   o_cmp = (i_data >= i_tdata2);
            TRIG_LT:   o_cmp = (i_data < i_tdata2);
            default:   o_cmp = 1'b0;
        endcase
    end

endmodule

// File: rtl/el2_dec_trigger_ctl.sv
// Decode-stage i0 trigger unit: per-channel compare, Nth-match hit counter and sticky hit status.
// Channel pairing is enabled by defining EL2_DEC_TRIG_CHAIN_EN.
module el2_dec_trigger_ctl
    import el2_pkg::*;
#(
    parameter int unsigned NUM_TRIG = 4,
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned PC_W     = 31
) (
    input  logic                                clk,
    input  logic                                rst_l,
    input  el2_trigger_pkt_t [NUM_TRIG-1:0]     trigger_pkt_any,
    input  logic [NUM_TRIG-1:0][1:0]            trig_mode,
    input  logic [NUM_TRIG-1:0]                 trig_chain,
    input  logic                                dec_i0_valid_d,
    input  logic                                dec_i0_stall_d,
    input  logic [PC_W:1]                       dec_i0_pc_d,
    input  logic [31:0]                         dec_i0_instr_d,
    input  logic [NUM_TRIG-1:0]                 cnt_wr_en,
    input  logic [CNT_W-1:0]                    cnt_wr_data,
    input  logic [NUM_TRIG-1:0]                 hit_clr,
    output logic [NUM_TRIG-1:0]                 dec_i0_trigger_match_d,
    output logic [NUM_TRIG-1:0]                 trig_hit,
    output logic [NUM_TRIG-1:0][CNT_W-1:0]      trig_cnt
);

    logic [NUM_TRIG-1:0]            w_cmp;
    logic [NUM_TRIG-1:0]            w_raw;
    logic [NUM_TRIG-1:0]            w_qual;
    logic [NUM_TRIG-1:0]            w_match;
    logic [NUM_TRIG-1:0]            w_dec_ok;
    logic [NUM_TRIG-1:0]            w_pkt_match;
    logic                           w_accept;
    logic [NUM_TRIG-1:0]            r_hit;
    logic [NUM_TRIG-1:0][CNT_W-1:0] r_cnt;

    assign w_accept = dec_i0_valid_d & ~dec_i0_stall_d;

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_ch
        el2_trig_mode_e w_mode;
        logic [31:0]    w_data;

        assign w_mode = el2_trig_mode_e'(trig_mode[i]);

        always_comb begin
            if (trigger_pkt_any[i].select) begin
                w_data = dec_i0_instr_d;
            end else if (w_mode inside {TRIG_GE, TRIG_LT}) begin
                w_data = 32'({dec_i0_pc_d, 1'b0});
            end else begin
                w_data = 32'({dec_i0_pc_d, trigger_pkt_any[i].tdata2[0]});
            end
        end

        el2_dec_trig_cmp u_cmp (
            .i_data   (w_data),
            .i_tdata2 (trigger_pkt_any[i].tdata2),
            .i_mode   (w_mode),
            .o_cmp    (w_cmp[i])
        );

        assign w_raw[i]       = trigger_pkt_any[i].execute & trigger_pkt_any[i].m &
                                dec_i0_valid_d & w_cmp[i];
        assign w_qual[i]      = w_raw[i] & (r_cnt[i] <= CNT_W'(1));
        assign w_pkt_match[i] = trigger_pkt_any[i].match;
    end

`ifdef EL2_DEC_TRIG_CHAIN_EN
    // A chained pair fires together and counts down only when both channels hit.
    always_comb begin
        w_match  = w_qual;
        w_dec_ok = w_raw;
        for (int unsigned k = 0; k + 1 < NUM_TRIG; k += 2) begin
            if (trig_chain[k]) begin
                w_match[k]    = w_qual[k] & w_qual[k+1];
                w_match[k+1]  = w_qual[k] & w_qual[k+1];
                w_dec_ok[k]   = w_raw[k] & w_raw[k+1];
                w_dec_ok[k+1] = w_raw[k] & w_raw[k+1];
            end
        end
    end
`else
    assign w_match  = w_qual;
    assign w_dec_ok = w_raw;
`endif

    // Compare mode comes from trig_mode; the packet's match bit is not used here.
    logic w_unused;
    assign w_unused = ^{trig_chain, w_pkt_match};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt <= '0;
            r_hit <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_TRIG; i++) begin
                if (cnt_wr_en[i]) begin
                    r_cnt[i] <= cnt_wr_data;
                end else if (w_accept && w_dec_ok[i] && (r_cnt[i] > CNT_W'(1))) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
                if (w_match[i] && w_accept) begin
                    r_hit[i] <= 1'b1;
                end else if (hit_clr[i]) begin
                    r_hit[i] <= 1'b0;
                end
            end
        end
    end

    assign dec_i0_trigger_match_d = w_match & {NUM_TRIG{rst_l}};
    assign trig_hit               = r_hit;
    assign trig_cnt               = r_cnt;

endmodule

// File: tb/tb_el2_dec_trigger_ctl.sv
// Randomised plus directed bench for el2_dec_trigger_ctl against a behavioural trigger model.
module tb_el2_dec_trigger_ctl;
    import el2_pkg::*;

    localparam int NT = 4;
    localparam int CW = 14;
    localparam int PW = 31;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    el2_trigger_pkt_t [NT-1:0] pkt;
    logic [NT-1:0][1:0] mode;
    logic [NT-1:0] chain, wr_en, clr;
    logic valid, stall;
    logic [PW:1] pc;
    logic [31:0] instr;
    logic [CW-1:0] wr_data;
    logic [NT-1:0] match, hit;
    logic [NT-1:0][CW-1:0] cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int m_cnt[NT];
    logic [NT-1:0] m_hit;

    logic [PW:1] pc_pool[4];
    logic [31:0] instr_pool[4];

    always #5 clk = ~clk;

    el2_dec_trigger_ctl #(.NUM_TRIG(NT), .CNT_W(CW), .PC_W(PW)) dut (
        .clk                    (clk),
        .rst_l                  (rst_l),
        .trigger_pkt_any        (pkt),
        .trig_mode              (mode),
        .trig_chain             (chain),
        .dec_i0_valid_d         (valid),
        .dec_i0_stall_d         (stall),
        .dec_i0_pc_d            (pc),
        .dec_i0_instr_d         (instr),
        .cnt_wr_en              (wr_en),
        .cnt_wr_data            (wr_data),
        .hit_clr                (clr),
        .dec_i0_trigger_match_d (match),
        .trig_hit               (hit),
        .trig_cnt               (cnt)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare result from the rules: NAPOT region size is found by counting trailing ones.
    function automatic bit cmp_f(int i);
        logic [31:0] t, d;
        int n;
        t = pkt[i].tdata2;
        if (pkt[i].select) d = instr;
        else if (mode[i] >= 2) d = {pc, 1'b0};
        else d = {pc, t[0]};
        case (mode[i])
            2'd0: return d == t;
            2'd1: begin
                n = 0;
                while (n < 32 && t[n]) n++;
                if (n >= 31) return 1'b1;
                return (d >> (n + 1)) == (t >> (n + 1));
            end
            2'd2: return d >= t;
            default: return d < t;
        endcase
    endfunction

    function automatic logic [NT-1:0] exp_match_f(output logic [NT-1:0] dec_ok);
        logic [NT-1:0] raw, q, mt;
        for (int i = 0; i < NT; i++) begin
            raw[i] = pkt[i].execute & pkt[i].m & valid & cmp_f(i);
            q[i] = raw[i] && (m_cnt[i] <= 1);
        end
        mt = q;
        dec_ok = raw;
`ifdef EL2_DEC_TRIG_CHAIN_EN
        for (int k = 0; k + 1 < NT; k += 2) begin
            if (chain[k]) begin
                mt[k] = q[k] & q[k+1];
                mt[k+1] = mt[k];
                dec_ok[k] = raw[k] & raw[k+1];
                dec_ok[k+1] = dec_ok[k];
            end
        end
`endif
        if (!rst_l) mt = '0;
        return mt;
    endfunction

    always @(negedge clk) begin
        logic [NT-1:0] dok;
        if (chk_en) begin
            chk("match_d", 64'(match), 64'(exp_match_f(dok)));
            chk("trig_hit", 64'(hit), 64'(m_hit));
            for (int i = 0; i < NT; i++) chk("trig_cnt", 64'(cnt[i]), 64'(m_cnt[i]));
        end
    end

    task automatic tick();
        logic [NT-1:0] mt, dok;
        bit acc;
        mt = exp_match_f(dok);
        acc = valid & ~stall;
        @(posedge clk);
        if (rst_l) begin
            for (int i = 0; i < NT; i++) begin
                if (wr_en[i]) m_cnt[i] = int'(wr_data);
                else if (acc && dok[i] && m_cnt[i] >= 2) m_cnt[i]--;
                if (mt[i] && acc) m_hit[i] = 1'b1;
                else if (clr[i]) m_hit[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_cnt[i] = 0;
        m_hit = '0;
    endtask

    task automatic clear_all();
        pkt = '0;
        mode = '0;
        chain = '0;
    endtask

    task automatic cfg(int i, bit sel, logic [1:0] md, logic [31:0] t);
        pkt[i] = '{select: sel, match: 1'b0, execute: 1'b1, m: 1'b1, tdata2: t};
        mode[i] = md;
    endtask

    task automatic rand_cfg();
        bit sel;
        logic [31:0] base, t;
        int k;
        for (int i = 0; i < NT; i++) begin
            sel = 1'($urandom);
            base = sel ? instr_pool[$urandom % 4] : {pc_pool[$urandom % 4], 1'b0};
            case ($urandom % 4)
                0: t = base;
                1: begin
                    k = $urandom % 12;
                    t = base | ((32'h1 << k) - 32'h1);
                end
                2: t = base + ($urandom % 64) - 32;
                default: t = $urandom;
            endcase
            pkt[i] = '{select: sel, match: 1'($urandom), execute: ($urandom % 8 != 0),
                       m: ($urandom % 8 != 0), tdata2: t};
            mode[i] = 2'($urandom);
        end
        chain = NT'($urandom);
    endtask

    initial begin
        clear_all();
        valid = 1'b0;
        stall = 1'b0;
        pc = '0;
        instr = '0;
        wr_en = '0;
        wr_data = '0;
        clr = '0;
        model_reset();
        #1;
        chk_en = 1'b1;
        #1 chk("reset_cnt0", 64'(cnt[0]), 64'd0);
        chk("reset_hit", 64'(hit), 64'd0);
        tick();
        tick();
        rst_l = 1'b1;

        // EQ on PC, then clear the sticky bit on a miss.
        cfg(0, 1'b0, 2'd0, 32'h8000_0100);
        pc = 31'h4000_0080;
        valid = 1'b1;
        #2 chk("eq_pc_match", 64'(match), 64'b0001);
        tick();
        chk("eq_pc_hit", 64'(hit), 64'b0001);
        clr[0] = 1'b1;
        pc = 31'h1;
        tick();
        clr = '0;
        chk("hit_clr", 64'(hit), 64'b0000);

        // NAPOT mask on opcode.
        clear_all();
        cfg(1, 1'b1, 2'd1, 32'h0000_007F);
        instr = 32'h0000_0013;
        #2 chk("mask_13", 64'(match), 64'b0010);
        instr = 32'h0000_0093;
        #2 chk("mask_93", 64'(match), 64'b0010);
        tick();

        // GE/LT window.
        clear_all();
        cfg(2, 1'b0, 2'd2, 32'h1000);
        cfg(3, 1'b0, 2'd3, 32'h2000);
        pc = 31'h0C00;
        #2 chk("window_in", 64'(match), 64'b1100);
        pc = 31'h1000;
        #2 chk("window_edge", 64'(match), 64'b0100);
        tick();

        // Fire on the third match; stalls do not count.
        clear_all();
        cfg(0, 1'b0, 2'd0, 32'h8000_0100);
        pc = 31'h4000_0080;
        valid = 1'b0;
        wr_en[0] = 1'b1;
        wr_data = 14'd3;
        tick();
        wr_en = '0;
        chk("cnt_load", 64'(cnt[0]), 64'd3);
        valid = 1'b1;
        stall = 1'b1;
        #2 chk("cnt3_nofire", 64'(match), 64'b0000);
        tick();
        tick();
        chk("cnt_stall", 64'(cnt[0]), 64'd3);
        stall = 1'b0;
        tick();
        chk("cnt_2", 64'(cnt[0]), 64'd2);
        #2 chk("cnt2_nofire", 64'(match), 64'b0000);
        tick();
        chk("cnt_1", 64'(cnt[0]), 64'd1);
        #2 chk("cnt1_fire", 64'(match), 64'b0001);
        tick();
        chk("cnt_hold1", 64'(cnt[0]), 64'd1);

        // Load beats a same-cycle decrement.
        valid = 1'b0;
        wr_en[0] = 1'b1;
        wr_data = 14'd4;
        tick();
        valid = 1'b1;
        wr_data = 14'd7;
        tick();
        wr_en = '0;
        chk("load_wins", 64'(cnt[0]), 64'd7);

        // Set beats clear.
        valid = 1'b0;
        wr_en[0] = 1'b1;
        wr_data = 14'd0;
        tick();
        wr_en = '0;
        valid = 1'b1;
        clr[0] = 1'b1;
        tick();
        clr = '0;
        chk("set_wins", 64'(hit[0]), 64'd1);

        // Asynchronous reset in the middle of a count.
        valid = 1'b0;
        wr_en[0] = 1'b1;
        wr_data = 14'd5;
        tick();
        wr_en = '0;
        valid = 1'b1;
        tick();
        chk("pre_rst_cnt", 64'(cnt[0]), 64'd4);
        rst_l = 1'b0;
        model_reset();
        #1 chk("rst_cnt", 64'(cnt[0]), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_match", 64'(match), 64'd0);
        tick();
        rst_l = 1'b1;
        #2 chk("post_rst_fire", 64'(match), 64'b0001);
        tick();

        // Chained pair.
        clear_all();
        cfg(0, 1'b0, 2'd0, 32'h8000_0100);
        cfg(1, 1'b0, 2'd0, 32'h0000_0000);
        chain = 4'b0001;
`ifdef EL2_DEC_TRIG_CHAIN_EN
        #2 chk("chain_one", 64'(match[1:0]), 64'b00);
`else
        #2 chk("chain_one", 64'(match[1:0]), 64'b01);
`endif
        cfg(1, 1'b0, 2'd0, 32'h8000_0100);
        #2 chk("chain_both", 64'(match[1:0]), 64'b11);
        tick();

        // Random traffic.
        for (int j = 0; j < 4; j++) begin
            pc_pool[j] = PW'($urandom);
            instr_pool[j] = $urandom;
        end
        for (int c = 0; c < 800; c++) begin
            if (c % 16 == 0) rand_cfg();
            pc = pc_pool[$urandom % 4];
            instr = instr_pool[$urandom % 4];
            valid = ($urandom % 5 != 0);
            stall = ($urandom % 5 == 0);
            for (int i = 0; i < NT; i++) begin
                wr_en[i] = ($urandom % 16 == 0);
                clr[i] = ($urandom % 5 == 0);
            end
            wr_data = CW'($urandom % 5);
            if ($urandom % 200 == 0) begin
                rst_l = 1'b0;
                model_reset();
                tick();
                rst_l = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/el2_dec_trigger_ctl.md
Name: el2_dec_trigger_ctl

Overview:
- Parametrised decode-stage trigger unit for i0: NUM_TRIG trigger channels, each matching PC or opcode.
- Four compare modes per channel; a per-channel hit counter (fire on Nth match); sticky hit status.
- Sits in dec between TLU trigger CSRs and the decode pipe. Drives dec_i0_trigger_match_d into the TLU debug/exception path.

Parameters:
NUM_TRIG, 4, number of trigger channels (1..8)
CNT_W, 14, hit-counter width in bits
PC_W, 31, PC width; bits [PC_W:1] are compared

Ports:
clk  input  1  core clock
rst_l  input  1  reset, asynchronous, active-low
trigger_pkt_any  input  NUM_TRIG x el2_trigger_pkt_t  per channel: select (0 = PC, 1 = opcode), match, execute, m, tdata2[31:0]
trig_mode  input  NUM_TRIG x 2  compare mode: 0 EQ, 1 MASK, 2 GE, 3 LT
trig_chain  input  NUM_TRIG  chain request; used only with the optional feature
dec_i0_valid_d  input  1  i0 valid in decode
dec_i0_stall_d  input  1  decode held this cycle
dec_i0_pc_d  input  PC_W  i0 PC, bits [PC_W:1]
dec_i0_instr_d  input  32  i0 instruction
cnt_wr_en  input  NUM_TRIG  load the hit counter of a channel
cnt_wr_data  input  CNT_W  hit-counter load value
hit_clr  input  NUM_TRIG  clear the sticky hit bit of a channel
dec_i0_trigger_match_d  output  NUM_TRIG  trigger fire, same cycle as the instruction
trig_hit  output  NUM_TRIG  sticky hit status
trig_cnt  output  NUM_TRIG x CNT_W  current hit-counter values

Behaviour:
- Compare data:
  - select = 0: {pc, tdata2[0]} for EQ and MASK; {pc, 1'b0} for GE and LT.
  - select = 1: instr[31:0].
- Compare modes, all unsigned 32-bit:
  - EQ: data == tdata2.
  - MASK: NAPOT mask-and-match. The trailing ones of tdata2 plus the next bit are don't-care; tdata2 all-ones matches everything.
  - GE: data >= tdata2.
  - LT: data < tdata2.
- raw[i] = execute & m & dec_i0_valid_d & cmp[i]. Purely combinational.
- accept = dec_i0_valid_d & ~dec_i0_stall_d. Counter and hit updates happen only on accept. The match output is combinational and may assert during a stall; it holds stable while PC and instruction are held.
- Per-channel counter cnt[i], reset value 0:
  - cnt == 0: fire on every raw match; counter unchanged.
  - cnt == 1: fire on every raw match; counter holds at 1.
  - cnt >= 2: no fire; decrement by 1 on raw & accept.
  - Counter never wraps.
- dec_i0_trigger_match_d[i] = raw[i] & (cnt[i] <= 1), after chain qualification.
- Sticky hit:
  - trig_hit[i] sets on match_d[i] & accept. Clears on hit_clr[i].
  - Set and clear in the same cycle: set wins.
- cnt_wr_en[i] loads cnt_wr_data next cycle and overrides a same-cycle decrement.
- Reset values: trig_hit = 0, trig_cnt = 0; match output is 0 while rst_l is low.
- Reset asserted mid-operation clears all state asynchronously. The first instruction after reset sees cnt = 0, i.e. fire-on-match.

Optional Feature:
- Macro: EL2_DEC_TRIG_CHAIN_EN.
- Defined:
  - Channels form pairs (2k, 2k+1).
  - If trig_chain[2k] = 1, both match_d[2k] and match_d[2k+1] assert only when both channels qualify on the same instruction. Neither decrements its counter unless both raw bits are set.
  - An odd NUM_TRIG leaves the last channel unchained.
- Undefined: trig_chain is ignored and all channels are independent.

Decomposition:
- Package el2_pkg gains:
  - typedef el2_trig_mode_e (TRIG_EQ, TRIG_MASK, TRIG_GE, TRIG_LT);
  - constant EL2_TRIG_MAX = 8.
- Sub-module el2_dec_trig_cmp: one channel's combinational comparator (data, tdata2, mode → cmp). Instantiated NUM_TRIG times.
- Counters, hit bits and chaining stay in the top module.

Test Plan:
- EQ PC match:
  - Stimulus: ch0 tdata2 = 0x8000_0100, select = 0, execute = 1, m = 1, valid, pc[31:1] = 0x4000_0080.
  - Required: match_d = 0001; trig_hit[0] = 1 next cycle.
  - Then pulse hit_clr[0] and the next instruction misses: trig_hit = 0.
- MASK opcode match:
  - Stimulus: ch1 select = 1, tdata2 = 0x0000_007F, instr = 0x0000_0013.
  - Required: match; instr 0x0000_0093 also matches.
- GE/LT window:
  - Stimulus: ch2 GE 0x1000, ch3 LT 0x2000, pc = 0x1800 >> 1.
  - Required: match_d = 1100.
  - pc = 0x2000 >> 1: match_d = 0100.
- Hit counter:
  - Stimulus: load cnt0 = 3; three matching instructions.
  - Required: no fire, no fire, fire; trig_cnt[0] reads 3 → 2 → 1 → 1.
  - With stall held, cnt is unchanged during the stall.
- Boundary cases:
  - cnt_wr_en together with a matching decrement: loaded value wins.
  - hit_clr together with a fire: trig_hit stays 1.
  - rst_l asserted mid-count: cnt = 0 and hit = 0 immediately.
- Chain, with EL2_DEC_TRIG_CHAIN_EN:
  - Stimulus: trig_chain[0] = 1; ch0 matches PC only.
  - Required: match_d[1:0] = 00.
  - When ch0 and ch1 both match: 11.
  - Without the macro: 01.
